// File: rtl/ram_rd_check_pkg.sv
// Shared defaults and FSM encoding for the RAM read-back checker.
package ram_rd_check_pkg;

    localparam int DEPTH_DEF  = 32;
    localparam int AW_DEF     = 5;
    localparam int DW_DEF     = 8;
    localparam int RD_LAT_DEF = 1;
    localparam int FRAME_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/rd_align_pipe.sv
// LAT-deep shift register delaying a valid flag and its payload together,
// so request-side fields line up with data returned by a fixed-latency memory.
module rd_align_pipe
    import ram_rd_check_pkg::*;
#(
    parameter int LAT = RD_LAT_DEF,
    parameter int W   = AW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_in,
    input  logic [W-1:0] data_in,
    output logic         en_out,
    output logic [W-1:0] data_out
);

    logic [LAT-1:0] en_sr;
    logic [W-1:0]   data_sr [LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_sr <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_sr[i] <= '0;
            end
        end else begin
            en_sr[0]   <= en_in;
            data_sr[0] <= data_in;
            for (int i = LAT - 1; i > 0; i--) begin
                en_sr[i]   <= en_sr[i-1];
                data_sr[i] <= data_sr[i-1];
            end
        end
    end

    assign en_out   = en_sr[LAT-1];
    assign data_out = data_sr[LAT-1];

endmodule

// File: rtl/ram_rd_check.sv
// Checks each word read back from the RAM against address + DATA_OFFSET and
// reports one pass/fail result per read burst.
//
// state  | meaning
// IDLE   | no burst in progress, waiting for an aligned enable
// CHECK  | burst in progress, counting samples and mismatches
// REPORT | one-cycle result publication; may reload for a back-to-back burst
module ram_rd_check
    import ram_rd_check_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int RD_LAT      = RD_LAT_DEF,
    parameter int DATA_OFFSET = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ram_rd_en,
    input  logic [AW-1:0]      ram_rd_addr,
    input  logic [DW-1:0]      ram_rd_data,
    output logic               chk_done,
    output logic               chk_pass,
    output logic [AW:0]        err_cnt,
    output logic [AW-1:0]      first_err_addr,
    output logic               first_err_vld,
    output logic               err_sticky,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic [AW:0] SMP_MAX  = (AW+1)'(DEPTH + 1);
    localparam logic [AW:0] SMP_FULL = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic          en_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] exp_data;
    logic          mism;

    logic [AW:0]   smp_cnt, smp_nxt;
    logic [AW:0]   wrk_err, err_nxt;
    logic [AW-1:0] wrk_first, first_nxt;
    logic          wrk_fvld, fvld_nxt;
    logic          load, accum, report_go, pass_nxt;

    rd_align_pipe #(
        .LAT (RD_LAT),
        .W   (AW)
    ) u_align (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_in    (ram_rd_en),
        .data_in  (ram_rd_addr),
        .en_out   (en_d),
        .data_out (addr_d)
    );

    assign exp_data = DW'(addr_d) + DW'(DATA_OFFSET);
    assign mism     = en_d && (ram_rd_data != exp_data);
    assign pass_nxt = (wrk_err == '0) && (smp_cnt == SMP_FULL);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accum     = 1'b0;
        report_go = 1'b0;
        smp_nxt   = smp_cnt;
        err_nxt   = wrk_err;
        first_nxt = wrk_first;
        fvld_nxt  = wrk_fvld;

        case (state)
            ST_IDLE: begin
                if (en_d) begin
                    state_nxt = ST_CHECK;
                    load      = 1'b1;
                end
            end
            ST_CHECK: begin
                if (en_d) begin
                    accum = 1'b1;
                end else begin
                    state_nxt = ST_REPORT;
                    report_go = 1'b1;
                end
            end
            ST_REPORT: begin
                // A sample arriving here starts the next burst immediately.
                if (en_d) begin
                    state_nxt = ST_CHECK;
                    load      = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (load) begin
            smp_nxt   = (AW+1)'(1);
            err_nxt   = {{AW{1'b0}}, mism};
            first_nxt = mism ? addr_d : '0;
            fvld_nxt  = mism;
        end else if (accum) begin
            if (smp_cnt != SMP_MAX) begin
                smp_nxt = smp_cnt + 1'b1;
            end
            if (mism) begin
                if (wrk_err != '1) begin
                    err_nxt = wrk_err + 1'b1;
                end
                if (!wrk_fvld) begin
                    first_nxt = addr_d;
                    fvld_nxt  = 1'b1;
                end
            end
        end
    end

    // Results are captured on the edge entering REPORT so they are valid
    // in the same cycle chk_done is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            smp_cnt        <= '0;
            wrk_err        <= '0;
            wrk_first      <= '0;
            wrk_fvld       <= 1'b0;
            chk_done       <= 1'b0;
            chk_pass       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_vld  <= 1'b0;
            err_sticky     <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            state     <= state_nxt;
            smp_cnt   <= smp_nxt;
            wrk_err   <= err_nxt;
            wrk_first <= first_nxt;
            wrk_fvld  <= fvld_nxt;
            chk_done  <= report_go;
            if (report_go) begin
                chk_pass       <= pass_nxt;
                err_cnt        <= wrk_err;
                first_err_addr <= wrk_first;
                first_err_vld  <= wrk_fvld;
                frame_cnt      <= frame_cnt + 1'b1;
                if (!pass_nxt) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: two instances (RD_LAT=1/offset 0, RD_LAT=2/offset 3)
// driven with the same burst table; results checked through a per-instance queue.
module tb_ram_rd_check;
    import ram_rd_check_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] dat_a = '0, dat_b = '0;
    logic [7:0] dly_a = '0, dly_b0 = '0, dly_b1 = '0;

    logic        chk_done_a, chk_pass_a, first_err_vld_a, err_sticky_a;
    logic [5:0]  err_cnt_a;
    logic [4:0]  first_err_addr_a;
    logic [15:0] frame_cnt_a;
    logic        chk_done_b, chk_pass_b, first_err_vld_b, err_sticky_b;
    logic [5:0]  err_cnt_b;
    logic [4:0]  first_err_addr_b;
    logic [15:0] frame_cnt_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM return path models for each latency
    always @(posedge clk) dly_a <= dat_a;
    always @(posedge clk) begin
        dly_b0 <= dat_b;
        dly_b1 <= dly_b0;
    end

    ram_rd_check #(.RD_LAT(1), .DATA_OFFSET(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ram_rd_en(en), .ram_rd_addr(addr),
        .ram_rd_data(dly_a), .chk_done(chk_done_a), .chk_pass(chk_pass_a),
        .err_cnt(err_cnt_a), .first_err_addr(first_err_addr_a),
        .first_err_vld(first_err_vld_a), .err_sticky(err_sticky_a),
        .frame_cnt(frame_cnt_a)
    );

    ram_rd_check #(.RD_LAT(2), .DATA_OFFSET(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ram_rd_en(en), .ram_rd_addr(addr),
        .ram_rd_data(dly_b1), .chk_done(chk_done_b), .chk_pass(chk_pass_b),
        .err_cnt(err_cnt_b), .first_err_addr(first_err_addr_b),
        .first_err_vld(first_err_vld_b), .err_sticky(err_sticky_b),
        .frame_cnt(frame_cnt_b)
    );

    // mode: 0 clean, 1 word idx forced to 8'hFF, 2 every word inverted
    typedef struct {
        int   len;
        int   mode;
        int   idx;
        int   gap;
        logic pass;
        int   err;
        int   faddr;
        logic fvld;
    } vec_t;

    typedef struct {
        logic pass;
        int   err;
        int   faddr;
        logic fvld;
        logic sticky;
        int   frame;
    } res_t;

    res_t q_a[$];
    res_t q_b[$];
    vec_t vecs[10];

    int   tests = 0;
    int   fails = 0;
    logic sticky_m = 1'b0;
    int   frame_m = 0;
    int   last_en_cyc = 0;
    int   done_cyc_a = 0;
    int   done_cyc_b = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic monitor();
        res_t e;
        if (chk_done_a) begin
            if (q_a.size() == 0) begin
                chk("a_spurious_done", chk_done_a, 0);
            end else begin
                e = q_a.pop_front();
                chk("a_pass", chk_pass_a, e.pass);
                chk("a_err_cnt", err_cnt_a, e.err);
                chk("a_first_addr", first_err_addr_a, e.faddr);
                chk("a_first_vld", first_err_vld_a, e.fvld);
                chk("a_sticky", err_sticky_a, e.sticky);
                chk("a_frame", frame_cnt_a, e.frame);
                done_cyc_a = cyc;
            end
        end
        if (chk_done_b) begin
            if (q_b.size() == 0) begin
                chk("b_spurious_done", chk_done_b, 0);
            end else begin
                e = q_b.pop_front();
                chk("b_pass", chk_pass_b, e.pass);
                chk("b_err_cnt", err_cnt_b, e.err);
                chk("b_first_addr", first_err_addr_b, e.faddr);
                chk("b_first_vld", first_err_vld_b, e.fvld);
                chk("b_sticky", err_sticky_b, e.sticky);
                chk("b_frame", frame_cnt_b, e.frame);
                done_cyc_b = cyc;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    function automatic logic [7:0] word(input int mode, input int idx, input int i, input int off);
        logic [7:0] e;
        e = 8'((i % 32) + off);
        if (mode == 2) return ~e;
        if (mode == 1 && i == idx) return 8'hFF;
        return e;
    endfunction

    task automatic push_exp(input vec_t v);
        res_t r;
        if (!v.pass) sticky_m = 1'b1;
        frame_m = (frame_m + 1) % 65536;
        r = '{v.pass, v.err, v.faddr, v.fvld, sticky_m, frame_m};
        q_a.push_back(r);
        q_b.push_back(r);
    endtask

    task automatic run_burst(input vec_t v);
        push_exp(v);
        for (int i = 0; i < v.len; i++) begin
            tick();
            en    = 1'b1;
            addr  = 5'(i % 32);
            dat_a = word(v.mode, v.idx, i, 0);
            dat_b = word(v.mode, v.idx, i, 3);
        end
        last_en_cyc = cyc + 1;
        for (int g = 0; g < v.gap; g++) begin
            tick();
            en    = 1'b0;
            dat_a = '0;
            dat_b = '0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (q_a.size() != 0 || q_b.size() != 0); k++) tick();
        chk("a_missing_done", q_a.size(), 0);
        chk("b_missing_done", q_b.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_done"}, chk_done_a, 0);
        chk({tag, "_a_pass"}, chk_pass_a, 0);
        chk({tag, "_a_err"}, err_cnt_a, 0);
        chk({tag, "_a_faddr"}, first_err_addr_a, 0);
        chk({tag, "_a_fvld"}, first_err_vld_a, 0);
        chk({tag, "_a_sticky"}, err_sticky_a, 0);
        chk({tag, "_a_frame"}, frame_cnt_a, 0);
        chk({tag, "_b_done"}, chk_done_b, 0);
        chk({tag, "_b_pass"}, chk_pass_b, 0);
        chk({tag, "_b_err"}, err_cnt_b, 0);
        chk({tag, "_b_faddr"}, first_err_addr_b, 0);
        chk({tag, "_b_fvld"}, first_err_vld_b, 0);
        chk({tag, "_b_sticky"}, err_sticky_b, 0);
        chk({tag, "_b_frame"}, frame_cnt_b, 0);
    endtask

    initial begin
        //            len mode idx gap  pass err faddr fvld
        vecs[0] = '{32, 0, 0,  32, 1'b1, 0,  0,  1'b0};
        vecs[1] = '{32, 1, 5,  4,  1'b0, 1,  5,  1'b1};
        vecs[2] = '{32, 0, 0,  4,  1'b1, 0,  0,  1'b0};
        vecs[3] = '{32, 2, 0,  4,  1'b0, 32, 0,  1'b1};
        vecs[4] = '{20, 0, 0,  4,  1'b0, 0,  0,  1'b0};
        vecs[5] = '{32, 0, 0,  1,  1'b1, 0,  0,  1'b0};
        vecs[6] = '{32, 1, 31, 4,  1'b0, 1,  31, 1'b1};
        vecs[7] = '{40, 0, 0,  4,  1'b0, 0,  0,  1'b0};
        vecs[8] = '{1,  1, 0,  4,  1'b0, 1,  0,  1'b1};
        vecs[9] = '{70, 2, 0,  6,  1'b0, 63, 0,  1'b1};

        rst_n = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        foreach (vecs[n]) run_burst(vecs[n]);
        drain();

        // reset asserted for one cycle at burst word 10; the partial burst is dropped
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 10) begin
                rst_n = 1'b0;
                en    = 1'b0;
                break;
            end
            en    = 1'b1;
            addr  = 5'(i);
            dat_a = word(0, 0, i, 0);
            dat_b = word(0, 0, i, 3);
        end
        tick();
        rst_n    = 1'b1;
        sticky_m = 1'b0;
        frame_m  = 0;
        repeat (6) tick();
        check_zero("midrst");

        run_burst('{32, 0, 0, 8, 1'b1, 0, 0, 1'b0});
        drain();
        chk("a_latency", done_cyc_a - last_en_cyc, 2);
        chk("b_latency", done_cyc_b - last_en_cyc, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
